// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side split-transaction memory bus.
package cpu_bus_pkg;

  // Requester identifiers, also stored in the owner FIFO
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    StFree,
    StLocked
  } lock_state_e;

  // Pointer width that stays legal for a depth of one
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small synchronous FIFO with async active-low clear; tracks which requester owns each
// accepted-but-unanswered memory transaction.
module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  logic             w_push_en;
  logic             w_pop_en;
  logic [PtrW-1:0]  w_wptr_nxt;
  logic [PtrW-1:0]  w_rptr_nxt;
  logic [CntW-1:0]  w_count_nxt;

  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rptr];

  // Overflow and underflow requests are dropped so the count can never wrap
  assign w_push_en = i_push & ~o_full;
  assign w_pop_en  = i_pop & ~o_empty;

  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_push_en) begin
      w_wptr_nxt = (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
    end
    if (w_pop_en) begin
      w_rptr_nxt = (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
    end
    unique case ({w_push_en, w_pop_en})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_en) begin
      r_mem[r_wptr] <= i_din;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the inst and data requesters onto one split-transaction memory port and
// routes in-order responses back to whichever requester issued each accepted request.
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,

  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [3:0]  i_inst_wstrb,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,

  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [3:0]  i_data_wstrb,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,

  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic [31:0] i_mem_rdata
);

  lock_state_e r_state;
  lock_state_e w_state_nxt;
  logic        r_owner;
  logic        w_owner_nxt;

  logic        w_sel;
  logic        w_sel_valid;
  logic        w_accept;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_head;

  always_comb begin
    w_sel       = REQ_INST;
    w_sel_valid = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_size  = SIZE_B;
    o_mem_addr  = '0;
    o_mem_wstrb = '0;
    o_mem_wdata = '0;

    // A stalled request keeps the port until the memory takes it
    if (r_state == StLocked) begin
      w_sel = r_owner;
    end else begin
      w_sel = i_data_req ? REQ_DATA : REQ_INST;
    end

    if (w_sel == REQ_DATA) begin
      w_sel_valid = i_data_req;
      o_mem_wr    = i_data_wr;
      o_mem_size  = i_data_size;
      o_mem_addr  = i_data_addr;
      o_mem_wstrb = i_data_wstrb;
      o_mem_wdata = i_data_wdata;
    end else begin
      w_sel_valid = i_inst_req;
      o_mem_wr    = i_inst_wr;
      o_mem_size  = i_inst_size;
      o_mem_addr  = i_inst_addr;
      o_mem_wstrb = i_inst_wstrb;
      o_mem_wdata = i_inst_wdata;
    end
  end

  // Reset gates the handshakes so they fall the moment resetn drops
  assign o_mem_req      = i_resetn & w_sel_valid & ~w_full;
  assign w_accept       = o_mem_req & i_mem_addr_ok;
  assign o_inst_addr_ok = w_accept & (w_sel == REQ_INST);
  assign o_data_addr_ok = w_accept & (w_sel == REQ_DATA);

  assign w_pop          = i_resetn & i_mem_data_ok & ~w_empty;
  assign o_inst_data_ok = w_pop & (w_head == REQ_INST);
  assign o_data_data_ok = w_pop & (w_head == REQ_DATA);
  assign o_inst_rdata   = i_mem_rdata;
  assign o_data_rdata   = i_mem_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    unique case (r_state)
      StFree: begin
        if (o_mem_req && !i_mem_addr_ok) begin
          w_state_nxt = StLocked;
          w_owner_nxt = w_sel;
        end
      end
      StLocked: begin
        if (i_mem_addr_ok) begin
          w_state_nxt = StFree;
        end
      end
      default: w_state_nxt = StFree;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= StFree;
      r_owner <= REQ_INST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  owner_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_push   (w_accept),
    .i_pop    (w_pop),
    .i_din    (w_sel),
    .o_dout   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

`ifndef SYNTHESIS
  a_req_held: assert property (@(posedge i_clk) disable iff (!i_resetn)
    (o_mem_req && !i_mem_addr_ok) |=> (o_mem_req && (o_mem_addr == $past(o_mem_addr))));
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: grant order, lock, full gating, routing, reset.
module tb_cpu_mem_arbiter;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(
    .MAX_OUT (2)
  ) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_inst_req     (inst_req),
    .i_inst_wr      (inst_wr),
    .i_inst_size    (inst_size),
    .i_inst_addr    (inst_addr),
    .i_inst_wstrb   (inst_wstrb),
    .i_inst_wdata   (inst_wdata),
    .o_inst_addr_ok (inst_addr_ok),
    .o_inst_data_ok (inst_data_ok),
    .o_inst_rdata   (inst_rdata),
    .i_data_req     (data_req),
    .i_data_wr      (data_wr),
    .i_data_size    (data_size),
    .i_data_addr    (data_addr),
    .i_data_wstrb   (data_wstrb),
    .i_data_wdata   (data_wdata),
    .o_data_addr_ok (data_addr_ok),
    .o_data_data_ok (data_data_ok),
    .o_data_rdata   (data_rdata),
    .o_mem_req      (mem_req),
    .o_mem_wr       (mem_wr),
    .o_mem_size     (mem_size),
    .o_mem_addr     (mem_addr),
    .o_mem_wstrb    (mem_wstrb),
    .o_mem_wdata    (mem_wdata),
    .i_mem_addr_ok  (mem_addr_ok),
    .i_mem_data_ok  (mem_data_ok),
    .i_mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = 32'h1c000000;
    inst_wstrb = 4'h0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SIZE_W; data_addr = 32'h00001000;
    data_wstrb = 4'h0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;

    // Reset: handshakes held low even with a request pending
    repeat (2) @(posedge clk);
    #1;
    inst_req = 1; mem_addr_ok = 1;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    inst_req = 0; mem_addr_ok = 0;
    next_cycle();
    resetn = 1;

    // 1. Single inst read
    inst_req = 1; mem_addr_ok = 1;
    settle();
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h1c000000);
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    check("t1_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("t1_c1_data_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h02800000;
    settle();
    check("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("t1_inst_rdata", inst_rdata, 32'h02800000);
    check("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    mem_data_ok = 0;

    // 2. Simultaneous requests: data first, inst next cycle
    inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'hf;
    data_wdata = 32'h12345678; mem_addr_ok = 1;
    settle();
    check("t2_mem_addr_data", mem_addr, 32'h00001000);
    check("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("t2_inst_addr_ok_lose", 32'(inst_addr_ok), 32'd0);
    check("t2_mem_wr", 32'(mem_wr), 32'd1);
    check("t2_mem_wstrb", 32'(mem_wstrb), 32'hf);
    check("t2_mem_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    data_req = 0; data_wr = 0; data_wstrb = 4'h0; data_wdata = '0;
    settle();
    check("t2_mem_addr_inst", mem_addr, 32'h1c000000);
    check("t2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("t2_mem_wr_rd", 32'(mem_wr), 32'd0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h11111111;
    settle();
    check("t2_resp0_data_ok", 32'(data_data_ok), 32'd1);
    check("t2_resp0_inst_ok", 32'(inst_data_ok), 32'd0);
    next_cycle();
    mem_rdata = 32'h22222222;
    settle();
    check("t2_resp1_inst_ok", 32'(inst_data_ok), 32'd1);
    check("t2_resp1_data_ok", 32'(data_data_ok), 32'd0);
    check("t2_resp1_rdata", inst_rdata, 32'h22222222);
    next_cycle();
    mem_data_ok = 0;

    // 3. Lock: stalled inst keeps the port while data arrives
    inst_req = 1; mem_addr_ok = 0;
    settle();
    check("t3_c0_mem_req", 32'(mem_req), 32'd1);
    check("t3_c0_mem_addr", mem_addr, 32'h1c000000);
    check("t3_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    next_cycle();
    data_req = 1;
    settle();
    check("t3_c1_mem_addr", mem_addr, 32'h1c000000);
    check("t3_c1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    settle();
    check("t3_c2_mem_addr", mem_addr, 32'h1c000000);
    next_cycle();
    mem_addr_ok = 1;
    settle();
    check("t3_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("t3_c3_mem_addr", mem_addr, 32'h1c000000);
    check("t3_c3_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    inst_req = 0;
    settle();
    check("t3_c4_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("t3_c4_mem_addr", mem_addr, 32'h00001000);
    next_cycle();

    // 4. Full: two outstanding (inst, data) blocks both requesters
    inst_req = 1;
    settle();
    check("t4_full_mem_req", 32'(mem_req), 32'd0);
    check("t4_full_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("t4_full_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'hAAAA0000;
    settle();
    check("t4_pop_mem_req", 32'(mem_req), 32'd0);
    check("t5_inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("t5_inst_rdata", inst_rdata, 32'hAAAA0000);
    check("t5_data_data_ok_0", 32'(data_data_ok), 32'd0);
    next_cycle();
    mem_data_ok = 0;
    settle();
    check("t4_reenable_mem_req", 32'(mem_req), 32'd1);
    check("t4_reenable_mem_addr", mem_addr, 32'h00001000);
    check("t4_reenable_data_addr_ok", 32'(data_addr_ok), 32'd1);
    next_cycle();

    // 5. Routing: remaining head is the data request
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h5555FFFF;
    settle();
    check("t5_data_data_ok", 32'(data_data_ok), 32'd1);
    check("t5_data_rdata", data_rdata, 32'h5555FFFF);
    check("t5_inst_data_ok_0", 32'(inst_data_ok), 32'd0);
    next_cycle();

    // 6. Reset mid-op with one outstanding and a lock held
    mem_data_ok = 0; inst_req = 1;
    settle();
    check("t6_lock_mem_req", 32'(mem_req), 32'd1);
    next_cycle();
    resetn = 0; mem_addr_ok = 1;
    #1;
    check("t6_rst_mem_req", 32'(mem_req), 32'd0);
    check("t6_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    inst_req = 0; mem_addr_ok = 0;
    next_cycle();
    resetn = 1;
    mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    check("t6_stray_inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("t6_stray_data_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
    settle();
    check("t6_unlocked_mem_req", 32'(mem_req), 32'd1);
    check("t6_unlocked_mem_addr", mem_addr, 32'h00001000);
    check("t6_unlocked_data_addr_ok", 32'(data_addr_ok), 32'd1);
    next_cycle();
    data_req = 0; inst_req = 1;
    settle();
    check("t6_second_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    next_cycle();
    data_req = 1;
    settle();
    check("t6_count_full_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
